// File: rtl/request_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | request_arbiter_pkg : shared state encodings, limits and helpers   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package request_arbiter_pkg;

  localparam int MAX_ARB_INPUTS = 8;
  localparam int IDX_W          = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/request_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | request_arbiter_if : requester/target handshake bundle             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface request_arbiter_if #(
  parameter int INPUTS = 4
);
  import request_arbiter_pkg::*;

  logic [INPUTS-1:0] requestValid;
  logic              targetAck;
  logic [INPUTS-1:0] grant;
  logic              grantValid;
  logic [INPUTS-1:0] ack;
  logic [INPUTS-1:0] error;
  logic [IDX_W-1:0]  grantIndex;

  modport master (
    input  requestValid, targetAck,
    output grant, grantValid, ack, error, grantIndex
  );

  modport slave (
    output requestValid, targetAck,
    input  grant, grantValid, ack, error, grantIndex
  );

endinterface
`default_nettype wire

// File: rtl/request_arbiter_round_robin_priority.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | round_robin_priority : combinational rotate/pick/rotate-back       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module round_robin_priority
  import request_arbiter_pkg::*;
#(
  parameter int INPUTS = 4
) (
  input  logic [INPUTS-1:0] i_request,
  input  logic [IDX_W-1:0]  i_lastGrant,
  output logic [INPUTS-1:0] o_nextGrant,
  output logic [IDX_W-1:0]  o_nextIndex,
  output logic              o_anyRequest
);

  localparam logic [IDX_W-1:0] c_last   = IDX_W'(INPUTS - 1);
  localparam logic [IDX_W:0]   c_inputs = (IDX_W + 1)'(INPUTS);

  logic [IDX_W-1:0]    w_start;
  logic [2*INPUTS-1:0] w_shift_r;
  logic [INPUTS-1:0]   w_rotated;
  logic [INPUTS-1:0]   w_pick_rot;
  logic [2*INPUTS-1:0] w_shift_l;
  logic [IDX_W-1:0]    w_offset;
  logic [IDX_W:0]      w_sum;

  always_comb begin
    w_start    = (i_lastGrant >= c_last) ? '0 : i_lastGrant + 3'd1;
    // rotate so the highest-priority requester lands on bit 0
    w_shift_r  = {i_request, i_request} >> w_start;
    w_rotated  = w_shift_r[INPUTS-1:0];
    w_pick_rot = w_rotated & (~w_rotated + 1'b1);
    w_shift_l  = {w_pick_rot, w_pick_rot} << w_start;
    w_offset   = '0;
    for (int j = INPUTS - 1; j >= 0; j--) begin
      if (w_rotated[j]) w_offset = IDX_W'(j);
    end
    w_sum = {1'b0, w_start} + {1'b0, w_offset};
    if (w_sum >= c_inputs) w_sum = w_sum - c_inputs;
  end

  assign o_nextGrant  = w_shift_l[2*INPUTS-1:INPUTS];
  assign o_nextIndex  = w_sum[IDX_W-1:0];
  assign o_anyRequest = |i_request;

endmodule
`default_nettype wire

// File: rtl/request_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | request_arbiter : round-robin grant FSM with timeout and ack route |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module request_arbiter
  import request_arbiter_pkg::*;
#(
  parameter int INPUTS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  request_arbiter_if.master bus
);

  localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] c_last_reset = IDX_W'(INPUTS - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [INPUTS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]  r_grantIndex, w_index_nxt;
  logic [IDX_W-1:0]  r_lastGrant, w_last_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic [INPUTS-1:0] w_pick_grant;
  logic [IDX_W-1:0]  w_pick_index;
  logic              w_any;
  logic              w_held;
  logic              w_timeout_hit;
  logic              w_release;
  logic              w_err_fire;

  round_robin_priority #(
    .INPUTS (INPUTS)
  ) u_pick (
    .i_request    (bus.requestValid),
    .i_lastGrant  (r_lastGrant),
    .o_nextGrant  (w_pick_grant),
    .o_nextIndex  (w_pick_index),
    .o_anyRequest (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_grantIndex <= '0;
      r_lastGrant  <= c_last_reset;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_grantIndex <= w_index_nxt;
      r_lastGrant  <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_index_nxt   = r_grantIndex;
    w_last_nxt    = r_lastGrant;
    w_cnt_nxt     = r_cnt;
    w_release     = 1'b0;
    w_err_fire    = 1'b0;
    w_held        = |(bus.requestValid & r_grant);
    w_timeout_hit = (TIMEOUT != 0) && (r_cnt == c_timeout);
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick_grant;
          w_index_nxt = w_pick_index;
          w_cnt_nxt   = '0;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (r_cnt != c_timeout) w_cnt_nxt = r_cnt + 1'b1;
        // ack beats abort beats timeout
        if (bus.targetAck) begin
          w_release = 1'b1;
        end else if (!w_held) begin
          w_release = 1'b1;
        end else if (w_timeout_hit) begin
          w_release  = 1'b1;
          w_err_fire = 1'b1;
        end
        if (w_release) begin
          w_grant_nxt = '0;
          w_index_nxt = '0;
          w_last_nxt  = r_grantIndex;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign bus.grant      = r_grant;
  assign bus.grantValid = |r_grant;
  assign bus.grantIndex = r_grantIndex;
  assign bus.ack        = r_grant & {INPUTS{bus.targetAck}};
  assign bus.error      = r_grant & {INPUTS{w_err_fire}};

endmodule
`default_nettype wire

// File: tb/tb_request_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_request_arbiter : directed self-checking bench                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_request_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  request_arbiter_if #(.INPUTS(4)) bus_a ();
  request_arbiter_if #(.INPUTS(4)) bus_b ();
  request_arbiter_if #(.INPUTS(1)) bus_c ();

  request_arbiter #(.INPUTS(4), .TIMEOUT(255)) u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  request_arbiter #(.INPUTS(4), .TIMEOUT(3))   u_tmo (.clk(clk), .rst(rst), .bus(bus_b));
  request_arbiter #(.INPUTS(1), .TIMEOUT(0))   u_one (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic look_a(input string tag, input logic [3:0] g, input logic [3:0] a, input logic [3:0] e);
    chk({tag, ".grant"}, 8'(bus_a.grant), 8'(g));
    chk({tag, ".ack"},   8'(bus_a.ack),   8'(a));
    chk({tag, ".error"}, 8'(bus_a.error), 8'(e));
  endtask

  task automatic look_b(input string tag, input logic [3:0] g, input logic [3:0] a, input logic [3:0] e);
    chk({tag, ".grant"}, 8'(bus_b.grant), 8'(g));
    chk({tag, ".ack"},   8'(bus_b.ack),   8'(a));
    chk({tag, ".error"}, 8'(bus_b.error), 8'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus_a.requestValid = '0; bus_a.targetAck = 1'b0;
    bus_b.requestValid = '0; bus_b.targetAck = 1'b0;
    bus_c.requestValid = '0; bus_c.targetAck = 1'b0;

    #3;
    look_a("reset", 4'b0000, 4'b0000, 4'b0000);
    chk("reset.valid", 8'(bus_a.grantValid), 8'd0);
    chk("reset.index", 8'(bus_a.grantIndex), 8'd0);
    look_b("reset_b", 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // single request
    bus_a.requestValid = 4'b0100;
    step(); #1;
    look_a("single.c1", 4'b0100, 4'b0000, 4'b0000);
    chk("single.index", 8'(bus_a.grantIndex), 8'd2);
    chk("single.valid", 8'(bus_a.grantValid), 8'd1);
    step(); step(); step();
    bus_a.targetAck = 1'b1; #1;
    look_a("single.c4", 4'b0100, 4'b0100, 4'b0000);
    step();
    bus_a.targetAck = 1'b0; bus_a.requestValid = '0; #1;
    look_a("single.c5", 4'b0000, 4'b0000, 4'b0000);
    chk("single.idle_index", 8'(bus_a.grantIndex), 8'd0);
    chk("single.idle_valid", 8'(bus_a.grantValid), 8'd0);

    // fresh priority for rotation
    step();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    bus_a.requestValid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("rot.grant", 8'(bus_a.grant), 8'(rot_exp[i]));
      bus_a.targetAck = 1'b1; #1;
      chk("rot.ack", 8'(bus_a.ack), 8'(rot_exp[i]));
      step();
      bus_a.targetAck = 1'b0;
      if (i == 4) bus_a.requestValid = '0;
      #1;
      chk("rot.dead", 8'(bus_a.grant), 8'd0);
    end

    // abort by requester 1, other bits wiggle meanwhile
    bus_a.requestValid = 4'b0010;
    step(); #1;
    chk("abort.grant", 8'(bus_a.grant), 8'b0010);
    chk("abort.index", 8'(bus_a.grantIndex), 8'd1);
    bus_a.requestValid = 4'b1011; #1;
    look_a("abort.busy", 4'b0010, 4'b0000, 4'b0000);
    step(); #1;
    chk("abort.held", 8'(bus_a.grant), 8'b0010);
    bus_a.requestValid = 4'b1001; #1;
    look_a("abort.drop", 4'b0010, 4'b0000, 4'b0000);
    step();
    bus_a.requestValid = 4'b0011; #1;
    look_a("abort.rel", 4'b0000, 4'b0000, 4'b0000);
    step(); #1;
    chk("abort.next", 8'(bus_a.grant), 8'b0001);
    bus_a.targetAck = 1'b1; #1;
    chk("abort.next_ack", 8'(bus_a.ack), 8'b0001);
    step();
    bus_a.targetAck = 1'b0; bus_a.requestValid = '0; #1;
    chk("abort.end", 8'(bus_a.grant), 8'd0);

    // stray ack while idle
    bus_a.targetAck = 1'b1; #1;
    look_a("stray", 4'b0000, 4'b0000, 4'b0000);
    step();
    bus_a.targetAck = 1'b0; #1;
    chk("stray.grant", 8'(bus_a.grant), 8'd0);
    chk("stray.valid", 8'(bus_a.grantValid), 8'd0);
    bus_a.requestValid = 4'b0110;
    step(); #1;
    chk("stray.next", 8'(bus_a.grant), 8'b0010);
    bus_a.targetAck = 1'b1;
    step();
    bus_a.targetAck = 1'b0; bus_a.requestValid = '0; #1;
    chk("stray.end", 8'(bus_a.grant), 8'd0);

    // asynchronous reset while requester 3 holds the grant
    bus_a.requestValid = 4'b1000;
    step(); #1;
    chk("rstmid.grant", 8'(bus_a.grant), 8'b1000);
    chk("rstmid.index", 8'(bus_a.grantIndex), 8'd3);
    bus_a.targetAck = 1'b1; #1;
    chk("rstmid.ack", 8'(bus_a.ack), 8'b1000);
    #1;
    rst = 1'b1; #1;
    look_a("rstmid.in", 4'b0000, 4'b0000, 4'b0000);
    chk("rstmid.valid", 8'(bus_a.grantValid), 8'd0);
    chk("rstmid.idx0", 8'(bus_a.grantIndex), 8'd0);
    #2;
    rst = 1'b0; bus_a.targetAck = 1'b0; bus_a.requestValid = 4'b1001;
    step(); #1;
    chk("rstmid.after", 8'(bus_a.grant), 8'b0001);
    bus_a.targetAck = 1'b1;
    step();
    bus_a.targetAck = 1'b0; bus_a.requestValid = '0;

    // timeout of 3: error in the 4th busy cycle
    bus_b.requestValid = 4'b0001;
    step(); #1; look_b("tmo.c1", 4'b0001, 4'b0000, 4'b0000);
    step(); #1; look_b("tmo.c2", 4'b0001, 4'b0000, 4'b0000);
    step(); #1; look_b("tmo.c3", 4'b0001, 4'b0000, 4'b0000);
    step(); #1; look_b("tmo.c4", 4'b0001, 4'b0000, 4'b0001);
    step();
    bus_b.requestValid = '0; #1;
    look_b("tmo.rel", 4'b0000, 4'b0000, 4'b0000);

    // ack coincident with timeout
    bus_b.requestValid = 4'b0001;
    step(); step(); step(); step();
    bus_b.targetAck = 1'b1; #1;
    look_b("tmo.both", 4'b0001, 4'b0001, 4'b0000);
    step();
    bus_b.targetAck = 1'b0; bus_b.requestValid = '0; #1;
    look_b("tmo.both_rel", 4'b0000, 4'b0000, 4'b0000);

    // single requester, timeout disabled
    bus_c.requestValid = 1'b1;
    step(); #1;
    chk("one.grant", 8'(bus_c.grant), 8'd1);
    chk("one.index", 8'(bus_c.grantIndex), 8'd0);
    for (int i = 0; i < 5; i++) step();
    #1;
    chk("one.noerr", 8'(bus_c.error), 8'd0);
    chk("one.hold", 8'(bus_c.grant), 8'd1);
    bus_c.targetAck = 1'b1; #1;
    chk("one.ack", 8'(bus_c.ack), 8'd1);
    step();
    bus_c.targetAck = 1'b0; #1;
    chk("one.dead", 8'(bus_c.grant), 8'd0);
    step(); #1;
    chk("one.regrant", 8'(bus_c.grant), 8'd1);
    bus_c.requestValid = 1'b0;
    step(); #1;
    chk("one.abort", 8'(bus_c.grant), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
